// File: rtl/gpio_packet_loader_pkg.sv
// Shared definitions for the SRAM test-chip GPIO front end: packet layout,
// idle packet value, state encoding and a small packet decode helper.
package test_chip_pkg;

    localparam int PKT_W    = 56;
    localparam int DATA_W   = 32;

    // Packet field bit positions
    localparam int CS_BIT   = 55;
    localparam int CSB0_BIT = 54;
    localparam int CSB1_BIT = 8;

    // Both port csb bits high, chip select low: the core sees no access
    localparam logic [PKT_W-1:0] IDLE_PACKET = 56'h40000000000100;

    // Loader state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RECV  = 3'd1;
    localparam state_t ST_ISSUE = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_SEND  = 3'd4;

    // A packet produces readback when either SRAM port is selected (csb low)
    function automatic logic needs_readback(input logic [PKT_W-1:0] pkt);
        return !pkt[CSB0_BIT] || !pkt[CSB1_BIT];
    endfunction

endpackage

// File: rtl/gpio_packet_loader_if.sv
// GPIO-side signal bundle of the packet loader. The loader is the slave;
// whatever drives the serial pins and consumes the readback is the master.
interface gpio_packet_loader_if;
    import test_chip_pkg::*;

    logic              start_in;
    logic              sdata_in;
    logic              svalid_in;
    logic [DATA_W-1:0] sram_data;
    logic [PKT_W-1:0]  gpio_packet;
    logic              sdata_out;
    logic              sdata_valid_out;
    logic              busy_out;
    logic              frame_err_out;

    modport slave (
        input  start_in, sdata_in, svalid_in, sram_data,
        output gpio_packet, sdata_out, sdata_valid_out, busy_out, frame_err_out
    );

    modport master (
        output start_in, sdata_in, svalid_in, sram_data,
        input  gpio_packet, sdata_out, sdata_valid_out, busy_out, frame_err_out
    );

endinterface

// File: rtl/gpio_packet_loader_piso_shifter.sv
// Parallel-load, serial-out shift register for the readback word.
// sout/valid are registered: a bit shifted on one edge is visible after it.
module piso_shifter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         sout,
    output logic         valid
);
    logic [W-1:0] data_reg;
    logic         sout_reg;
    logic         valid_reg;

    // Load the word, then present its MSB and shift left once per shift cycle
    always_ff @(posedge clk) begin
        if (srst) begin
            data_reg  <= '0;
            sout_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            if (load) begin
                data_reg <= din;
            end else if (shift) begin
                data_reg <= {data_reg[W-2:0], 1'b0};
            end
            sout_reg  <= shift ? data_reg[W-1] : 1'b0;
            valid_reg <= shift;
        end
    end

    assign sout  = sout_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/gpio_packet_loader.sv
// Serial front end for the SRAM test chip: deserialises a command packet,
// holds it on gpio_packet for ISSUE_CYCLES, waits READ_LAT cycles, captures
// sram_data and shifts it back out MSB first.
module gpio_packet_loader
    import test_chip_pkg::*;
#(
    parameter int ISSUE_CYCLES = 2,
    parameter int READ_LAT     = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    gpio_packet_loader_if.slave bus
);
    localparam logic [3:0]         ISSUE_LAST = 4'(ISSUE_CYCLES - 1);
    localparam logic [3:0]         WAIT_LAST  = 4'(READ_LAT - 1);
    localparam int                 SEND_CW    = $clog2(DATA_W);
    localparam logic [SEND_CW-1:0] SEND_LAST  = SEND_CW'(DATA_W - 1);
    localparam logic [5:0]         LAST_BIT   = 6'(PKT_W - 1);

    state_t               state_reg, state_next;
    // Only the first PKT_W-1 bits are stored; the final bit comes from the pin
    logic [PKT_W-2:0]     rx_shift_reg, rx_shift_next;
    logic [5:0]           bit_cnt_reg, bit_cnt_next;
    logic [3:0]           phase_cnt_reg, phase_cnt_next;
    logic [SEND_CW-1:0]   send_cnt_reg, send_cnt_next;
    logic [PKT_W-1:0]     gpio_reg, gpio_next;
    logic                 busy_reg, busy_next;
    logic                 err_reg, err_next;
    logic                 rd_load;
    logic                 rd_shift;
    logic                 rd_sout;
    logic                 rd_valid;

    // Next-state and datapath decisions for the receive/issue/readback sequence
    always_comb begin
        state_next     = state_reg;
        rx_shift_next  = rx_shift_reg;
        bit_cnt_next   = bit_cnt_reg;
        phase_cnt_next = phase_cnt_reg;
        send_cnt_next  = send_cnt_reg;
        gpio_next      = gpio_reg;
        err_next       = err_reg;
        rd_load        = 1'b0;
        rd_shift       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start_in) begin
                    state_next    = ST_RECV;
                    rx_shift_next = '0;
                    bit_cnt_next  = '0;
                end
            end
            ST_RECV: begin
                if (bus.start_in) begin
                    // A restart with bits already taken abandons a frame
                    if (bit_cnt_reg != 6'd0) begin
                        err_next = 1'b1;
                    end
                    rx_shift_next = '0;
                    bit_cnt_next  = '0;
                end else if (bus.svalid_in) begin
                    rx_shift_next = {rx_shift_reg[PKT_W-3:0], bus.sdata_in};
                    if (bit_cnt_reg == LAST_BIT) begin
                        gpio_next      = {rx_shift_reg, bus.sdata_in};
                        bit_cnt_next   = '0;
                        phase_cnt_next = '0;
                        state_next     = ST_ISSUE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 6'd1;
                    end
                end
            end
            ST_ISSUE: begin
                if (phase_cnt_reg == ISSUE_LAST) begin
                    gpio_next      = IDLE_PACKET;
                    phase_cnt_next = '0;
                    state_next     = needs_readback(gpio_reg) ? ST_WAIT : ST_IDLE;
                end else begin
                    phase_cnt_next = phase_cnt_reg + 4'd1;
                end
            end
            ST_WAIT: begin
                if (phase_cnt_reg == WAIT_LAST) begin
                    rd_load        = 1'b1;
                    phase_cnt_next = '0;
                    send_cnt_next  = '0;
                    state_next     = ST_SEND;
                end else begin
                    phase_cnt_next = phase_cnt_reg + 4'd1;
                end
            end
            ST_SEND: begin
                rd_shift = 1'b1;
                if (send_cnt_reg == SEND_LAST) begin
                    send_cnt_next = '0;
                    state_next    = ST_IDLE;
                end else begin
                    send_cnt_next = send_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next == ST_ISSUE) || (state_next == ST_WAIT) ||
                    (state_next == ST_SEND);
    end

    // State and output registers; reset returns the core to the idle packet
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg     <= ST_IDLE;
            rx_shift_reg  <= '0;
            bit_cnt_reg   <= '0;
            phase_cnt_reg <= '0;
            send_cnt_reg  <= '0;
            gpio_reg      <= IDLE_PACKET;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rx_shift_reg  <= rx_shift_next;
            bit_cnt_reg   <= bit_cnt_next;
            phase_cnt_reg <= phase_cnt_next;
            send_cnt_reg  <= send_cnt_next;
            gpio_reg      <= gpio_next;
            busy_reg      <= busy_next;
            err_reg       <= err_next;
        end
    end

    piso_shifter #(
        .W (DATA_W)
    ) u_readback (
        .clk   (clk_in),
        .srst  (rst_in),
        .load  (rd_load),
        .shift (rd_shift),
        .din   (bus.sram_data),
        .sout  (rd_sout),
        .valid (rd_valid)
    );

    assign bus.gpio_packet     = gpio_reg;
    assign bus.busy_out        = busy_reg;
    assign bus.frame_err_out   = err_reg;
    assign bus.sdata_out       = rd_sout;
    assign bus.sdata_valid_out = rd_valid;

endmodule

// File: tb/tb_gpio_packet_loader.sv
// Bench for gpio_packet_loader: table of whole-packet scenarios, hand-written
// abort / busy / reset sequences, and random pin activity, all checked every
// cycle against a timeline-based reference model.
module tb_gpio_packet_loader;
    import test_chip_pkg::*;

    localparam int IC = 2;
    localparam int RL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpio_packet_loader_if bus();

    gpio_packet_loader #(
        .ISSUE_CYCLES (IC),
        .READ_LAT     (RL)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_mis = 0;

    // ---------------- reference model ----------------
    // Receive: a queue of bits since the last start. Once 56 arrive, the whole
    // output timeline follows from the completion cycle t_done.
    int               cyc = 0;
    int               t_done = 0;
    bit               m_rx = 0, m_has = 0, m_err = 0, m_busy_prev = 0;
    logic             m_bits[$];
    logic [PKT_W-1:0] m_pkt = '0;
    logic [DATA_W-1:0] m_word = '0;
    logic [PKT_W-1:0] e_gpio = IDLE_PACKET;
    logic             e_sout = 0, e_valid = 0, e_busy = 0, e_err = 0;

    task automatic model_edge(input logic st, input logic sv, input logic sd,
                              input logic r, input logic [DATA_W-1:0] word);
        int off;
        bit rd;
        int blen;
        cyc++;
        if (r) begin
            m_rx = 0; m_has = 0; m_err = 0; m_bits.delete();
        end else if (!m_busy_prev) begin
            if (st) begin
                if (m_rx && m_bits.size() != 0) m_err = 1;
                m_rx = 1;
                m_bits.delete();
            end else if (m_rx && sv) begin
                m_bits.push_back(sd);
                if (m_bits.size() == PKT_W) begin
                    for (int i = 0; i < PKT_W; i++) m_pkt[PKT_W-1-i] = m_bits[i];
                    m_bits.delete();
                    m_rx = 0; m_has = 1; t_done = cyc;
                end
            end
        end
        off = cyc - t_done;
        if (m_has && off == IC + RL) m_word = word;
        rd      = m_has && (!m_pkt[CSB0_BIT] || !m_pkt[CSB1_BIT]);
        blen    = rd ? IC + RL + DATA_W : IC;
        e_gpio  = (m_has && off < IC) ? m_pkt : IDLE_PACKET;
        e_busy  = m_has && off < blen;
        e_valid = rd && off >= IC + RL + 1 && off <= IC + RL + DATA_W;
        e_sout  = e_valid ? m_word[DATA_W-1-(off-IC-RL-1)] : 1'b0;
        e_err   = m_err;
        m_busy_prev = e_busy;
    endtask

    // ---------------- per-window observations ----------------
    int               obs_idx = 0, obs_busy = 0, obs_valid = 0, obs_first = -1;
    logic [DATA_W-1:0] obs_word = '0;
    logic [PKT_W-1:0] obs_pkt0 = '0;

    task automatic obs_clear();
        obs_idx = 0; obs_busy = 0; obs_valid = 0; obs_first = -1;
        obs_word = '0; obs_pkt0 = '0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive pins, advance the model at the edge, compare just after
    task automatic tick(input logic st, input logic sv, input logic sd, input string tag);
        logic [PKT_W+3:0] act, exp;
        bus.start_in  = st;
        bus.svalid_in = sv;
        bus.sdata_in  = sd;
        @(posedge clk);
        model_edge(st, sv, sd, rst, bus.sram_data);
        #1;
        act = {bus.gpio_packet, bus.sdata_out, bus.sdata_valid_out, bus.busy_out, bus.frame_err_out};
        exp = {e_gpio, e_sout, e_valid, e_busy, e_err};
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s cyc %0d: {gpio,sout,valid,busy,err} got %h expected %h", tag, cyc, act, exp);
        end
        if (obs_idx == 0) obs_pkt0 = bus.gpio_packet;
        if (bus.busy_out) obs_busy++;
        if (bus.sdata_valid_out) begin
            if (obs_first < 0) obs_first = obs_idx;
            obs_valid++;
            obs_word = {obs_word[DATA_W-2:0], bus.sdata_out};
        end
        obs_idx++;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'($urandom), tag);
    endtask

    // Start pulse then 56 bits MSB first, optionally with a dead cycle before each
    task automatic send_frame(input logic [PKT_W-1:0] pkt, input bit gap, input string tag);
        tick(1'b1, 1'b0, 1'b0, tag);
        for (int i = PKT_W - 1; i >= 0; i--) begin
            if (gap) tick(1'b0, 1'b0, 1'($urandom), tag);
            if (i == 0) obs_clear();
            tick(1'b0, 1'b1, pkt[i], tag);
        end
    endtask

    task automatic frame_checks(input string tag, input logic [PKT_W-1:0] pkt,
                                input logic [DATA_W-1:0] word, input int eb,
                                input int ev, input int ef, input logic ee);
        check({tag, "_pkt"},   obs_pkt0, pkt);
        check({tag, "_busy"},  obs_busy, eb);
        check({tag, "_valid"}, obs_valid, ev);
        check({tag, "_first"}, obs_first, ef);
        if (ev > 0) check({tag, "_word"}, obs_word, word);
        check({tag, "_err"},   bus.frame_err_out, ee);
    endtask

    typedef struct {
        logic [PKT_W-1:0]  pkt;
        logic [DATA_W-1:0] word;
        bit                gap;
        int                exp_busy;
        int                exp_valid;
        int                exp_first;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [PKT_W-1:0] p;

        vecs[0] = '{56'hC0000012345600, 32'hDEADBEEF, 1'b0, 37, 32,  6};
        vecs[1] = '{56'h40000000000100, 32'h11111111, 1'b0,  2,  0, -1};
        vecs[2] = '{56'hC0000012345600, 32'h12345678, 1'b1, 37, 32,  6};
        vecs[3] = '{56'hC0000000000000, 32'hA5A50F0F, 1'b0, 37, 32,  6};
        vecs[4] = '{56'h80000000000100, 32'h00000001, 1'b1, 37, 32,  6};
        vecs[5] = '{56'hFFFFFFFFFFFFFF, 32'hFFFFFFFF, 1'b0,  2,  0, -1};

        bus.start_in = 0; bus.svalid_in = 0; bus.sdata_in = 0; bus.sram_data = '0;

        // Reset state
        rst = 1'b1;
        idle(3, "reset");
        check("reset_gpio",  bus.gpio_packet, IDLE_PACKET);
        check("reset_valid", bus.sdata_valid_out, 0);
        check("reset_busy",  bus.busy_out, 0);
        check("reset_err",   bus.frame_err_out, 0);
        rst = 1'b0;
        idle(3, "idle");
        // svalid without a start is ignored in IDLE
        for (int i = 0; i < 60; i++) tick(1'b0, 1'b1, 1'b1, "idle_svalid");
        check("idle_svalid_gpio", bus.gpio_packet, IDLE_PACKET);

        // Table-driven packet scenarios
        for (int v = 0; v < 6; v++) begin
            bus.sram_data = vecs[v].word;
            send_frame(vecs[v].pkt, vecs[v].gap, $sformatf("vec%0d", v));
            idle(45, $sformatf("vec%0d", v));
            frame_checks($sformatf("vec%0d", v), vecs[v].pkt, vecs[v].word,
                         vecs[v].exp_busy, vecs[v].exp_valid, vecs[v].exp_first, 1'b0);
        end

        // Start pulsed while bit 10 of the readback is on the pin: ignored
        p = IDLE_PACKET; p[CS_BIT] = 1'b1; p[CSB0_BIT] = 1'b0;
        bus.sram_data = 32'h0F1E2D3C;
        send_frame(p, 1'b0, "busyrej");
        idle(16, "busyrej");
        tick(1'b1, 1'b0, 1'b0, "busyrej");
        idle(30, "busyrej");
        frame_checks("busyrej", p, 32'h0F1E2D3C, 37, 32, 6, 1'b0);

        // Abort: 20 bits then a restart, followed by a complete frame
        bus.sram_data = 32'hCAFEF00D;
        tick(1'b1, 1'b0, 1'b0, "abort");
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'($urandom), "abort");
        send_frame(56'hC0000012345600, 1'b0, "abort");
        idle(45, "abort");
        frame_checks("abort", 56'hC0000012345600, 32'hCAFEF00D, 37, 32, 6, 1'b1);

        // Reset while readback bit 5 is on the pin
        bus.sram_data = 32'h13579BDF;
        send_frame(56'hC0000012345600, 1'b0, "rstsend");
        idle(11, "rstsend");
        check("rstsend_prevalid", bus.sdata_valid_out, 1);
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, "rstsend");
        rst = 1'b0;
        check("rstsend_valid", bus.sdata_valid_out, 0);
        check("rstsend_gpio",  bus.gpio_packet, IDLE_PACKET);
        check("rstsend_busy",  bus.busy_out, 0);
        check("rstsend_err",   bus.frame_err_out, 0);
        bus.sram_data = 32'h2468ACE0;
        send_frame(56'hC0000012345600, 1'b0, "postrst");
        idle(45, "postrst");
        frame_checks("postrst", 56'hC0000012345600, 32'h2468ACE0, 37, 32, 6, 1'b0);

        // Random pin activity against the model
        for (int k = 0; k < 5000; k++) begin
            bus.sram_data = $urandom;
            rst = ($urandom_range(0, 1499) == 0);
            tick($urandom_range(0, 119) == 0, $urandom_range(0, 7) != 0,
                 1'($urandom), "random");
        end
        rst = 1'b0;
        idle(50, "tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
